// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - RV32IM integer register file with two write ports and busy scoreboard
//
// Purpose: NREGS x XLEN register file with NREAD combinational read ports,
// a main-pipeline write port (0), a long-latency write port (1) and a
// per-register busy scoreboard for long-latency destinations.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   rsi / rs / rs_busy          read indices, read data, read-port busy flags
//   write_enable, rdi, rd       write port 0 (pipeline writeback)
//   lw_enable, lw_rdi, lw_rd    write port 1 (mul/div writeback, clears busy)
//   res_valid, res_rdi          reservation request (marks register busy)
//   wr_conflict                 registered: both write ports hit same index
//   busy_vec                    registered scoreboard state
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int IDXW = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*IDXW-1:0]   rsi,
  output logic [NREAD*XLEN-1:0]   rs,
  output logic [NREAD-1:0]        rs_busy,
  input  logic                    write_enable,
  input  logic [IDXW-1:0]         rdi,
  input  logic [XLEN-1:0]         rd,
  input  logic                    lw_enable,
  input  logic [IDXW-1:0]         lw_rdi,
  input  logic [XLEN-1:0]         lw_rd,
  input  logic                    res_valid,
  input  logic [IDXW-1:0]         res_rdi,
  output logic                    wr_conflict,
  output logic [NREGS-1:0]        busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Port 1 is assigned last so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (write_enable && rdi != '0) regs[rdi] <= rd;
      if (lw_enable && lw_rdi != '0) regs[lw_rdi] <= lw_rd;
    end
  end

  // A new reservation beats a writeback clear of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NREGS; i++) begin
        if (res_valid && res_rdi == IDXW'(i))
          busy[i] <= 1'b1;
        else if (lw_enable && lw_rdi == IDXW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_conflict <= 1'b0;
    else
      wr_conflict <= write_enable && lw_enable && (rdi == lw_rdi) && (rdi != '0);
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] data;
    logic            lw_hit;
    logic            wr_hit;

    assign idx    = rsi[k*IDXW +: IDXW];
    assign lw_hit = lw_enable && (lw_rdi == idx);
    assign wr_hit = write_enable && (rdi == idx);

    // Forwarding keeps decode from seeing stale data; reset forces zero so
    // in-flight writes presented during reset cannot leak onto the bus.
    always_comb begin
      data = '0;
      if (!rst_n || idx == '0)
        data = '0;
      else if (lw_hit)
        data = lw_rd;
      else if (wr_hit)
        data = rd;
      else
        data = regs[idx];
    end

    assign rs[k*XLEN +: XLEN] = data;
    // The writeback cycle already forwards data, so the reader need not stall.
    assign rs_busy[k] = rst_n && busy[idx] && !lw_hit;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised RV32IM integer register file: `NREAD` combinational read ports, two write ports and a per-register busy scoreboard. Write port 0 serves the main pipeline writeback. Write port 1 serves the long-latency multiply/divide unit, which reserves its destination at issue and clears it at writeback. The block sits between decode (reads, busy checks) and the two writeback paths. Same-cycle write-to-read forwarding means decode never sees stale data.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `NREGS`, 32, register count (power of two, ≥2); `IDXW = $clog2(NREGS)`.
- `NREAD`, 2, number of read ports (≥1).

Ports (clock is `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `rsi` in NREAD*IDXW: read indices; port k uses bits [k*IDXW +: IDXW].
- `rs` out NREAD*XLEN: read data, port k in [k*XLEN +: XLEN].
- `rs_busy` out NREAD: read port k's register has a pending reservation.
- `write_enable` in 1: port 0 write strobe.
- `rdi` in IDXW: port 0 write index.
- `rd` in XLEN: port 0 write data.
- `lw_enable` in 1: port 1 (long-latency) write strobe; also clears busy.
- `lw_rdi` in IDXW: port 1 write index.
- `lw_rd` in XLEN: port 1 write data.
- `res_valid` in 1: reserve request.
- `res_rdi` in IDXW: register to mark busy.
- `wr_conflict` out 1: registered flag; both write ports targeted the same nonzero index last cycle.
- `busy_vec` out NREGS: full scoreboard state, registered.

## Operation
- Storage: NREGS×XLEN flops. Index 0 is hardwired zero: writes to it are dropped, it always reads 0, and it is never busy. Reserving index 0 is ignored.
- Writes occur on the rising edge. Port 0 writes `rd` to `rdi` when `write_enable`=1. Port 1 writes `lw_rd` to `lw_rdi` when `lw_enable`=1.
- Same-index write collision (both enables, same nonzero index): port 1 data is stored, and `wr_conflict`=1 the next cycle only.
- Read data for port k is resolved with this priority: index 0 gives 0; else a matching port-1 write this cycle gives `lw_rd`; else a matching port-0 write this cycle gives `rd`; else the stored value.
- Scoreboard, one bit per register, updated per edge at index i:
  - `res_valid` && `res_rdi`==i sets the bit. This takes priority over a clear of the same index in the same cycle (new reservation wins).
  - Otherwise `lw_enable` && `lw_rdi`==i clears the bit.
  - A port-0 write does not affect busy.
  - Reserving an already-busy index leaves it busy. There is no counting.
- `rs_busy[k]` = busy bit of `rsi[k]`, gated low when `lw_enable` && `lw_rdi`==`rsi[k]` in the same cycle. Forwarding already supplies the data, so a reader never stalls in the writeback cycle.
- Reset (asynchronous, `rst_n`=0): all registers 0, all busy bits 0, `wr_conflict`=0. While in reset, `rs` reads 0 and `rs_busy` reads 0. Writes and reservations presented during reset are lost. Deassertion is synchronised externally.

## Timing
- Read path is fully combinational: index to `rs` in 0 cycles, including forwarding.
- Write to architectural state takes 1 edge. A read in a later cycle returns the stored value.
- Reserve takes 1 edge. `rs_busy` and `busy_vec` assert in the cycle after `res_valid`.
- Busy clear: `rs_busy` drops combinationally in the `lw_enable` cycle. `busy_vec` drops after the edge.
- `wr_conflict` is valid 1 cycle after the collision and lasts 1 cycle.
- No internal stall or backpressure. All inputs are sampled every edge.

## Test plan
- Reset, then write: `rst_n`=0 → all `rs`=0, `busy_vec`=0. Release, write `rd`=0x12345 to `rdi`=4 → next cycle, `rsi[0]`=4 reads 0x12345.
- Forwarding: same cycle `write_enable`, `rdi`=3, `rd`=0x98765 with `rsi[1]`=3 → `rs[1]`=0x98765 combinationally, before the edge.
- x0: write 0xDEADBEEF to index 0, reserve index 0 → reads 0, `busy_vec[0]`=0, `rs_busy`=0.
- Scoreboard:
  - Reserve 7 → next cycle `rs_busy[0]`=1 for `rsi[0]`=7.
  - `lw_enable`, `lw_rdi`=7, `lw_rd`=0xCAFE → same cycle `rs_busy[0]`=0 and `rs[0]`=0xCAFE. Next cycle `busy_vec[7]`=0.
- Simultaneous events:
  - Reserve 9 and `lw_enable` on 9 in one cycle → 9 stays busy.
  - Both write ports to 5 (`rd`=1, `lw_rd`=2) → 5 holds 2, `wr_conflict`=1 for exactly one cycle.
- Reset mid-operation: registers 1..3 written, 6 reserved, assert `rst_n`=0 between edges → outputs zero immediately, `busy_vec`=0. After release, 6 reads 0 and not busy.
